bomb_spawn_sched: RTL and testbench
===================================

# bomb_spawn_sched

Spawn scheduler for the falling-bomb game logic. Counts frame ticks, and when the spawn interval expires it picks a free bomb slot round-robin. It latches that slot's 8-bit random value from the LFSR bomb-position generator, clamps the value into the playfield row range, and hands a spawn request to the bomb renderer over a valid/ready handshake. It also tracks which of the three bomb slots are in flight.

## Interface
Parameters:
- `SPAWN_INTERVAL`, default 30: frame ticks between spawn attempts; 0 is treated as 1.
- `MIN_INTERVAL`, default 8: floor for the interval when speed-up is compiled in.
- `SPEEDUP_EVERY`, default 4: number of accepted spawns per interval decrement (speed-up only).
- `Y_MIN`, default 16: lowest legal spawn row.
- `Y_MAX`, default 223: highest legal spawn row; `Y_MIN` ≤ `Y_MAX` is required.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset.
- `enable`  in  1: game running.
- `frame_tick`  in  1: one-cycle pulse per video frame.
- `rand_num0`, `rand_num1`, `rand_num2`  in  8 each: per-slot random values from the LFSR generator.
- `bomb_done`  in  3: one-cycle pulse per slot when that bomb has left the screen or exploded.
- `spawn_ready`  in  1: renderer accepts the spawn request.
- `spawn_valid`  out  1: spawn request pending.
- `spawn_slot`  out  2: slot index 0..2.
- `spawn_y`  out  8: clamped spawn row.
- `bomb_active`  out  3: slot-occupied flags.
- `interval_cur`  out  8: current effective interval.

## Operation
- States:
  - IDLE: waits for `enable`=1, then goes to COUNT with the frame counter at 0.
  - COUNT: the frame counter increments on each `frame_tick`. When the counter reaches `interval_cur`-1 and a tick arrives, the counter clears and the FSM goes to PICK.
  - PICK: takes one cycle when a slot is free. The slot chosen is the first free slot at or after `rr_ptr`, modulo 3. The FSM latches the slot index and the clamped value, then goes to ISSUE. If no slot is free, the FSM stays in PICK; frame ticks are not counted while it waits.
  - ISSUE: holds `spawn_valid`=1 with `spawn_slot` and `spawn_y` stable. On `spawn_ready`, it sets `bomb_active[slot]`, sets `rr_ptr` to slot+1 (mod 3), and returns to COUNT.
- Clamp rule: y = rand if Y_MIN ≤ rand ≤ Y_MAX; y = Y_MIN if rand < Y_MIN; y = Y_MAX if rand > Y_MAX. The comparison is unsigned 8-bit.
- `bomb_done[i]` clears `bomb_active[i]`. A done pulse on an inactive slot is ignored.
- If set and clear hit the same slot in the same cycle, set wins. This case cannot occur legally and is defined for robustness only.
- `enable` falling in any state sends the FSM to IDLE next cycle, drops `spawn_valid`, and clears the frame counter. `bomb_active` and `rr_ptr` are retained.

## Timing
- Reset values:
  - `spawn_valid`=0, `spawn_slot`=0, `spawn_y`=Y_MIN, `bomb_active`=0.
  - `interval_cur`=SPAWN_INTERVAL (or 1 if SPAWN_INTERVAL=0).
  - FSM=IDLE, `rr_ptr`=0, frame counter=0.
- Reset asserted mid-handshake drops `spawn_valid` immediately (asynchronous) and discards the pending spawn.
- Latency from the expiring `frame_tick` to `spawn_valid`=1 is 2 cycles: COUNT→PICK, then PICK→ISSUE.
- Random values are sampled in the PICK cycle only. Later changes on `rand_num*` do not alter `spawn_y` while in ISSUE.
- Acceptance occurs on the cycle where `spawn_valid`=1 and `spawn_ready`=1. `bomb_active` updates on the next edge, and `spawn_valid` is 0 on the next cycle.
- `spawn_ready` asserted while `spawn_valid`=0 is ignored.
- `frame_tick` arriving during PICK or ISSUE is not counted.

## Configuration
- Macro: `BOMB_SPAWN_SPEEDUP_EN`.
- Defined:
  - A 3-bit accepted-spawn counter runs. On each `SPEEDUP_EVERY`-th acceptance, `interval_cur` decrements by 1, saturating at `MIN_INTERVAL`.
  - The speed-up counter and `interval_cur` are reset only by `rst`, not by `enable`.
- Undefined: `interval_cur` is fixed at SPAWN_INTERVAL and no counter is built.

## Test plan
- Interval: reset, `enable`=1, SPAWN_INTERVAL=3, `spawn_ready` tied to 1, one tick every 10 cycles → first `spawn_valid` 2 cycles after the 3rd tick, with `spawn_slot`=0 and `bomb_active`=001 after acceptance.
- Clamp: `rand_num0` driven to 5, 100 and 250 on three spawns → `spawn_y` = 16, 100 and 223.
- Round-robin and full: no `bomb_done` pulses → spawns go to slots 0, 1, 2 in order. The 4th interval stalls in PICK with no `spawn_valid`. A `bomb_done`=010 pulse → next spawn to slot 1 within 2 cycles.
- Handshake hold: `spawn_ready`=0 for 20 cycles while `rand_num*` toggles → `spawn_valid`, `spawn_slot` and `spawn_y` are stable. `spawn_ready`=1 → accepted, then valid=0.
- Reset mid-ISSUE, and `enable`=0 mid-ISSUE:
  - `rst` low → all outputs return to reset values.
  - `enable`=0 → valid drops and `bomb_active` is unchanged.
- `BOMB_SPAWN_SPEEDUP_EN` with SPAWN_INTERVAL=10, MIN_INTERVAL=8, SPEEDUP_EVERY=4:
  - 12 accepted spawns → `interval_cur` steps 10→9→8 and stays at 8.
  - Without the macro → `interval_cur` stays 10.

Source files
------------

// File: rtl/bomb_spawn_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bomb_spawn_sched                                                |
// | Purpose  : Frame-tick spawn timer, round-robin free-slot picker, row clamp |
// |            and valid/ready spawn request for three bomb slots.             |
// | Options  : BOMB_SPAWN_SPEEDUP_EN - shrink the interval as spawns accrue.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bomb_spawn_sched #(
  parameter int SPAWN_INTERVAL = 30,
  parameter int MIN_INTERVAL   = 8,
  parameter int SPEEDUP_EVERY  = 4,
  parameter int Y_MIN          = 16,
  parameter int Y_MAX          = 223
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [7:0] rand_num0,
  input  logic [7:0] rand_num1,
  input  logic [7:0] rand_num2,
  input  logic [2:0] bomb_done,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [1:0] spawn_slot,
  output logic [7:0] spawn_y,
  output logic [2:0] bomb_active,
  output logic [7:0] interval_cur
);

  localparam logic [7:0] c_init_interval = 8'((SPAWN_INTERVAL == 0) ? 1 : SPAWN_INTERVAL);
  localparam logic [7:0] c_y_min         = 8'(Y_MIN);
  localparam logic [7:0] c_y_max         = 8'(Y_MAX);

  if (Y_MIN > Y_MAX || SPEEDUP_EVERY < 1 || SPEEDUP_EVERY > 8 ||
      MIN_INTERVAL < 1 || MIN_INTERVAL > 255) begin : g_cfg_check
    $error("bomb_spawn_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PICK  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_rr_ptr;
  logic       r_valid;
  logic [1:0] r_slot;
  logic [7:0] r_y;
  logic [2:0] r_active;

  logic [1:0] w_c0, w_c1, w_c2, w_pick;
  logic       w_any_free;
  logic [7:0] w_rand, w_clamp;
  logic       w_accept;
  logic [2:0] w_set;

  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign w_c0     = r_rr_ptr;
  assign w_c1     = next_slot(w_c0);
  assign w_c2     = next_slot(w_c1);
  assign w_accept = r_valid & spawn_ready;
  assign w_set    = w_accept ? (3'b001 << r_slot) : 3'b000;

  // First free slot at or after the round-robin pointer, then its clamped row.
  always_comb begin
    w_any_free = 1'b1;
    w_pick     = w_c0;
    if (!r_active[w_c0])      w_pick = w_c0;
    else if (!r_active[w_c1]) w_pick = w_c1;
    else if (!r_active[w_c2]) w_pick = w_c2;
    else                      w_any_free = 1'b0;

    case (w_pick)
      2'd0:    w_rand = rand_num0;
      2'd1:    w_rand = rand_num1;
      default: w_rand = rand_num2;
    endcase

    if (w_rand < c_y_min)      w_clamp = c_y_min;
    else if (w_rand > c_y_max) w_clamp = c_y_max;
    else                       w_clamp = w_rand;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_rr_ptr <= 2'd0;
      r_valid  <= 1'b0;
      r_slot   <= 2'd0;
      r_y      <= c_y_min;
      r_active <= 3'b000;
    end else begin
      // Set beats clear so a same-cycle done cannot drop a fresh spawn.
      r_active <= (r_active & ~bomb_done) | w_set;
      if (w_accept) r_rr_ptr <= next_slot(r_slot);

      if (!enable) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_cnt   <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_COUNT;
            r_cnt   <= 8'd0;
          end
          S_COUNT: begin
            if (frame_tick) begin
              if (r_cnt >= interval_cur - 8'd1) begin
                r_cnt   <= 8'd0;
                r_state <= S_PICK;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          S_PICK: begin
            if (w_any_free) begin
              r_slot  <= w_pick;
              r_y     <= w_clamp;
              r_valid <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (spawn_ready) begin
              r_valid <= 1'b0;
              r_state <= S_COUNT;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef BOMB_SPAWN_SPEEDUP_EN
  localparam logic [2:0] c_every_m1     = 3'(SPEEDUP_EVERY - 1);
  localparam logic [7:0] c_min_interval = 8'(MIN_INTERVAL);

  logic [2:0] r_acc_cnt;
  logic [7:0] r_interval;

  // Only the hard reset rewinds difficulty; pausing the game keeps it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_cnt  <= 3'd0;
      r_interval <= c_init_interval;
    end else if (w_accept) begin
      if (r_acc_cnt == c_every_m1) begin
        r_acc_cnt <= 3'd0;
        if (r_interval > c_min_interval) r_interval <= r_interval - 8'd1;
      end else begin
        r_acc_cnt <= r_acc_cnt + 3'd1;
      end
    end
  end

  assign interval_cur = r_interval;
`else
  assign interval_cur = c_init_interval;
`endif

  assign spawn_valid = r_valid;
  assign spawn_slot  = r_slot;
  assign spawn_y     = r_y;
  assign bomb_active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_bomb_spawn_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bomb_spawn_sched                                             |
// | Purpose  : Directed, table-driven self-checking bench for bomb_spawn_sched.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bomb_spawn_sched;

  typedef struct {
    logic [2:0] done;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [1:0] slot;
    logic [7:0] y;
  } spawn_rec_t;

  logic       clk = 1'b0;
  logic       rst, enable, frame_tick, spawn_ready;
  logic [7:0] rand_num0, rand_num1, rand_num2;
  logic [2:0] bomb_done;
  logic       spawn_valid;
  logic [1:0] spawn_slot;
  logic [7:0] spawn_y;
  logic [2:0] bomb_active;
  logic [7:0] interval_cur;

  logic       en2, tick2, ready2;
  logic [7:0] rz2;
  logic [2:0] done2;
  logic       v2;
  logic [1:0] slot2;
  logic [7:0] y2;
  logic [2:0] act2;
  logic [7:0] int2;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] m_active;
  spawn_rec_t recs[10];

  always #5 clk = ~clk;

  bomb_spawn_sched #(
    .SPAWN_INTERVAL(3), .MIN_INTERVAL(3), .SPEEDUP_EVERY(4), .Y_MIN(16), .Y_MAX(223)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .rand_num0(rand_num0), .rand_num1(rand_num1), .rand_num2(rand_num2),
    .bomb_done(bomb_done), .spawn_ready(spawn_ready), .spawn_valid(spawn_valid),
    .spawn_slot(spawn_slot), .spawn_y(spawn_y), .bomb_active(bomb_active),
    .interval_cur(interval_cur)
  );

  // Second instance exercises the interval speed-up; slots free themselves.
  assign done2 = act2;
  bomb_spawn_sched #(
    .SPAWN_INTERVAL(10), .MIN_INTERVAL(8), .SPEEDUP_EVERY(4), .Y_MIN(16), .Y_MAX(223)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .frame_tick(tick2),
    .rand_num0(rz2), .rand_num1(rz2), .rand_num2(rz2),
    .bomb_done(done2), .spawn_ready(ready2), .spawn_valid(v2),
    .spawn_slot(slot2), .spawn_y(y2), .bomb_active(act2),
    .interval_cur(int2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (spawn_valid) break;
    end
    check({tag, " valid"}, 32'(spawn_valid), 1);
  endtask

  function automatic int exp_int(input int k);
    int e;
`ifdef BOMB_SPAWN_SPEEDUP_EN
    e = 10 - k / 4;
    if (e < 8) e = 8;
`else
    e = 10;
`endif
    return e;
  endfunction

  // One spawn with spawn_ready held high; m_active is the bench's slot model.
  task automatic do_spawn(input spawn_rec_t r, input string tag);
    @(posedge clk); #1;
    rand_num0 = r.r0; rand_num1 = r.r1; rand_num2 = r.r2; bomb_done = r.done;
    @(posedge clk); #1 bomb_done = 3'b000;
    m_active = m_active & ~r.done;
    pulse_tick();
    pulse_tick();
    @(negedge clk);
    check({tag, " early valid"}, 32'(spawn_valid), 0);
    check({tag, " pre active"}, 32'(bomb_active), 32'(m_active));
    pulse_tick();
    wait_valid(tag);
    check({tag, " slot"}, 32'(spawn_slot), 32'(r.slot));
    check({tag, " y"}, 32'(spawn_y), 32'(r.y));
    m_active = m_active | (3'b001 << r.slot);
    @(negedge clk);
    check({tag, " valid drop"}, 32'(spawn_valid), 0);
    check({tag, " active"}, 32'(bomb_active), 32'(m_active));
  endtask

  initial begin
    int k;
    recs[0] = '{3'b000, 8'd9,   8'd240, 8'd0,   2'd1, 8'd223};
    recs[1] = '{3'b000, 8'd1,   8'd2,   8'd130, 2'd2, 8'd130};
    recs[2] = '{3'b001, 8'd250, 8'd3,   8'd3,   2'd0, 8'd223};
    recs[3] = '{3'b101, 8'd100, 8'd77,  8'd5,   2'd2, 8'd16};
    recs[4] = '{3'b000, 8'd100, 8'd0,   8'd0,   2'd0, 8'd100};
    recs[5] = '{3'b010, 8'd0,   8'd16,  8'd0,   2'd1, 8'd16};
    recs[6] = '{3'b100, 8'd0,   8'd0,   8'd223, 2'd2, 8'd223};
    recs[7] = '{3'b001, 8'd15,  8'd0,   8'd0,   2'd0, 8'd16};
    recs[8] = '{3'b001, 8'd224, 8'd0,   8'd0,   2'd0, 8'd223};
    recs[9] = '{3'b000, 8'd40,  8'd0,   8'd0,   2'd0, 8'd40};

    rst = 1'b0; enable = 1'b0; frame_tick = 1'b0; spawn_ready = 1'b0;
    rand_num0 = 8'd0; rand_num1 = 8'd0; rand_num2 = 8'd0; bomb_done = 3'b000;
    en2 = 1'b0; tick2 = 1'b1; ready2 = 1'b1; rz2 = 8'd50;
    m_active = 3'b000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset valid", 32'(spawn_valid), 0);
    check("reset slot", 32'(spawn_slot), 0);
    check("reset y", 32'(spawn_y), 16);
    check("reset active", 32'(bomb_active), 0);
    check("reset interval", 32'(interval_cur), 3);
    check("reset interval2", 32'(int2), 10);
    rst = 1'b1;

    // First spawn: slow ticks, exact two-cycle latency, low clamp on slot 0.
    @(posedge clk); #1 enable = 1'b1; spawn_ready = 1'b1; rand_num0 = 8'd5;
    for (int t = 0; t < 3; t++) begin
      repeat (8) @(posedge clk);
      pulse_tick();
      if (t < 2) begin
        @(negedge clk);
        check("interval early valid", 32'(spawn_valid), 0);
      end
    end
    @(negedge clk);
    check("latency pick cycle", 32'(spawn_valid), 0);
    @(negedge clk);
    check("latency issue cycle", 32'(spawn_valid), 1);
    check("first slot", 32'(spawn_slot), 0);
    check("first y", 32'(spawn_y), 16);
    @(negedge clk);
    check("first valid drop", 32'(spawn_valid), 0);
    check("first active", 32'(bomb_active), 1);
    m_active = 3'b001;

    for (int i = 0; i < 9; i++) do_spawn(recs[i], $sformatf("rec%0d", i));

    // All slots busy: PICK stalls and ignores ticks until a slot frees.
    repeat (7) pulse_tick();
    @(negedge clk);
    check("full no valid", 32'(spawn_valid), 0);
    check("full active", 32'(bomb_active), 7);
    @(posedge clk); #1 rand_num1 = 8'd100; bomb_done = 3'b010;
    @(posedge clk); #1 bomb_done = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("unstall valid", 32'(spawn_valid), 1);
    check("unstall slot", 32'(spawn_slot), 1);
    check("unstall y", 32'(spawn_y), 100);
    @(negedge clk);
    check("unstall active", 32'(bomb_active), 7);

    // Held request stays stable while the random inputs churn.
    spawn_ready = 1'b0;
    @(posedge clk); #1 rand_num0 = 8'd60; bomb_done = 3'b001;
    @(posedge clk); #1 bomb_done = 3'b000;
    repeat (3) pulse_tick();
    wait_valid("hold");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rand_num0 = 8'($urandom); rand_num1 = 8'($urandom); rand_num2 = 8'($urandom);
      @(negedge clk);
      check("hold valid", 32'(spawn_valid), 1);
      check("hold slot", 32'(spawn_slot), 0);
      check("hold y", 32'(spawn_y), 60);
    end
    @(posedge clk); #1 spawn_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hold accept valid", 32'(spawn_valid), 0);
    check("hold accept active", 32'(bomb_active), 7);

    // enable drop mid-request discards it and keeps slot state.
    spawn_ready = 1'b0;
    @(posedge clk); #1 rand_num2 = 8'd200; bomb_done = 3'b100;
    @(posedge clk); #1 bomb_done = 3'b000;
    repeat (3) pulse_tick();
    wait_valid("disable");
    check("disable slot", 32'(spawn_slot), 2);
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("disable valid drop", 32'(spawn_valid), 0);
    check("disable active kept", 32'(bomb_active), 3);
    @(posedge clk); #1 enable = 1'b1; spawn_ready = 1'b1;
    m_active = 3'b011;
    begin
      spawn_rec_t r;
      r = '{3'b000, 8'd0, 8'd0, 8'd200, 2'd2, 8'd200};
      do_spawn(r, "reenable");
    end

    // Asynchronous reset in the middle of a pending request.
    spawn_ready = 1'b0;
    @(posedge clk); #1 rand_num0 = 8'd150; bomb_done = 3'b001;
    @(posedge clk); #1 bomb_done = 3'b000;
    repeat (3) pulse_tick();
    wait_valid("midreset");
    check("midreset y", 32'(spawn_y), 150);
    #2 rst = 1'b0;
    #1;
    check("async valid", 32'(spawn_valid), 0);
    check("async slot", 32'(spawn_slot), 0);
    check("async y", 32'(spawn_y), 16);
    check("async active", 32'(bomb_active), 0);
    check("async interval", 32'(interval_cur), 3);
    @(negedge clk); rst = 1'b1; spawn_ready = 1'b1;
    m_active = 3'b000;
    do_spawn(recs[9], "postreset");

    // Interval speed-up (or its absence) over twelve accepted spawns.
    @(posedge clk); #1 en2 = 1'b1;
    k = 0;
    for (int c = 0; c < 400 && k < 12; c++) begin
      @(negedge clk);
      if (v2) begin
        @(negedge clk);
        k++;
        check($sformatf("speedup interval k%0d", k), 32'(int2), 32'(exp_int(k)));
      end
    end
    check("speedup accepts", 32'(k), 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
